snake_head_ctrl: RTL and testbench
==================================

// Module: snake_head_ctrl
// PURPOSE
//  Movement controller for the snake-head sprite in the 640x640 bordered play field.
//  Sequences the sprite position once per N video frames, accepts direction commands over a valid/ready handshake,
//  and detects wall collision.
//  Drives the x/y position registers consumed by the sprite-compositing stage.
//  Runs on the 74.25 MHz pixel clock alongside the video timing generator.
// PARAMETERS
//  GRID            32    tile size in pixels; one step moves the head by exactly GRID
//  FIELD_MIN       32    lowest legal top-left coordinate (inner edge of the 32 px border)
//  FIELD_MAX       576   highest legal top-left coordinate (640-32-GRID)
//  START_X         320   head x loaded at reset / restart
//  START_Y         320   head y loaded at reset / restart
//  FRAMES_PER_STEP 8     frame ticks per movement step (>=1)
//  V_TICK          720   i_vcnt value that marks the frame tick (first blanking line)
// PORTS
//  i_clk_74M    in   1   74.25 MHz pixel clock
//  i_rst_n      in   1   reset, synchronous, active-low
//  i_vcnt       in   12  vertical counter from timing generator
//  i_hcnt       in   12  horizontal counter from timing generator
//  i_start      in   1   start/restart request, level sampled each clock
//  i_dir_valid  in   1   direction command valid
//  i_dir        in   2   0=right 1=down 2=left 3=up
//  o_dir_ready  out  1   controller can accept a direction command
//  o_x_pos      out  12  head top-left x, registered
//  o_y_pos      out  12  head top-left y, registered
//  o_step       out  1   one-cycle pulse, high in the cycle after o_x_pos/o_y_pos update
//  o_state      out  2   0=IDLE 1=RUN 2=DEAD
//  o_game_over  out  1   high while in DEAD
// BEHAVIOUR
//  Reset values (i_rst_n low at a clock edge, any state, mid-step included):
//   o_x_pos=START_X, o_y_pos=START_Y, cur_dir=0, pending empty, frame cnt=0, state IDLE.
//   o_step=0, o_dir_ready=0, o_game_over=0.
//  Frame tick: one-cycle internal pulse when i_vcnt==V_TICK && i_hcnt==0.
//  FSM:
//   IDLE -> RUN on i_start=1. Frame cnt is cleared. Position is unchanged.
//   RUN: each tick increments frame cnt. A tick with cnt==FRAMES_PER_STEP-1 is a step: cnt->0, and the step executes.
//   RUN -> DEAD when a step would leave [FIELD_MIN,FIELD_MAX] on either axis. Position holds its pre-step value. o_step still pulses.
//   DEAD -> RUN on i_start=1. Reloads START_X/START_Y, sets cur_dir=0, clears pending, clears cnt.
//  Direction handshake: o_dir_ready = (state==RUN) && pending empty.
//   A transfer occurs when i_dir_valid && o_dir_ready at a clock edge. i_dir is stored in the 1-entry pending register.
//   A transfer in the same cycle as a step goes to pending for the NEXT step. It is not applied to the current step.
//   At a step, the pending entry is consumed. cur_dir takes it unless it is a reversal (i_dir == cur_dir^2). A reversal is discarded silently.
//  Step arithmetic (12-bit unsigned). Bounds are checked before add/sub, so there is no underflow:
//   right: collide if x > FIELD_MAX-GRID, else x+=GRID. left: collide if x < FIELD_MIN+GRID, else x-=GRID.
//   down/up: same rule applied to y.
//  Latency: o_x_pos/o_y_pos update on the clock edge after the tick cycle. o_step is high one cycle after that update.
//  Ticks are ignored in IDLE and in DEAD. i_start is ignored in RUN.
// CONFIGURATION
//  SNAKE_WRAP_EN defined: no collision.
//   Leaving the field wraps to the opposite legal edge (right from 576 -> 32, up from 32 -> 576, etc.).
//   DEAD is unreachable and o_game_over stays 0.
//  SNAKE_WRAP_EN undefined: collision -> DEAD as described above.
// TESTING
//  1 Reset, i_start pulse, 8 ticks, no dir -> x 320->352, y 320, one o_step pulse, o_state=1.
//  2 RUN, dir=1 accepted, then dir=3 offered -> ready low until next step. After step y=352. dir=3 then accepted.
//    At the following step it is a reversal and is discarded: y=384.
//  3 Head at x=576, dir right, step -> o_state=2, o_game_over=1, x stays 576. Later i_start -> x=320, y=320, RUN.
//  4 Dir handshake coincident with the step cycle -> current step uses old dir. New dir is applied at the next step.
//  5 i_rst_n low during RUN at cnt=5 with pending valid -> all outputs return to their reset values next edge.
//  6 SNAKE_WRAP_EN: x=32 moving left, step -> x=576, o_game_over stays 0. y=576 moving down, step -> y=32.

Source files
------------

// File: rtl/snake_head_ctrl.sv
// Snake-head movement controller for the 640x640 bordered play field.
// Steps the head one GRID tile every FRAMES_PER_STEP frame ticks. Accepts
// direction commands through a one-entry pending register over a valid/ready
// handshake. Detects wall collision, or wraps at the walls when SNAKE_WRAP_EN
// is defined.
//
// Build option:
//   SNAKE_WRAP_EN  when defined, leaving the field wraps to the opposite legal
//                  edge, and DEAD / o_game_over are never reached.
//
// Ports:
//   i_clk_74M    74.25 MHz pixel clock
//   i_rst_n      synchronous active-low reset
//   i_vcnt       vertical counter from the timing generator
//   i_hcnt       horizontal counter from the timing generator
//   i_start      start/restart request, level sampled every clock
//   i_dir_valid  direction command valid
//   i_dir        direction: 0=right 1=down 2=left 3=up
//   o_dir_ready  a direction command can be accepted (RUN and pending empty)
//   o_x_pos      head top-left x
//   o_y_pos      head top-left y
//   o_step       one-cycle pulse, high in the cycle after a position update
//   o_state      0=IDLE 1=RUN 2=DEAD
//   o_game_over  high while in DEAD
module snake_head_ctrl #(
    parameter int unsigned GRID            = 32,
    parameter int unsigned FIELD_MIN       = 32,
    parameter int unsigned FIELD_MAX       = 576,
    parameter int unsigned START_X         = 320,
    parameter int unsigned START_Y         = 320,
    parameter int unsigned FRAMES_PER_STEP = 8,
    parameter int unsigned V_TICK          = 720
) (
    input  logic        i_clk_74M,
    input  logic        i_rst_n,
    input  logic [11:0] i_vcnt,
    input  logic [11:0] i_hcnt,
    input  logic        i_start,
    input  logic        i_dir_valid,
    input  logic [1:0]  i_dir,
    output logic        o_dir_ready,
    output logic [11:0] o_x_pos,
    output logic [11:0] o_y_pos,
    output logic        o_step,
    output logic [1:0]  o_state,
    output logic        o_game_over
);

    localparam int unsigned POS_W = 12;
    localparam int unsigned CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [POS_W-1:0] GRID_P   = POS_W'(GRID);
    localparam logic [POS_W-1:0] FMIN_P   = POS_W'(FIELD_MIN);
    localparam logic [POS_W-1:0] FMAX_P   = POS_W'(FIELD_MAX);
    localparam logic [POS_W-1:0] START_XP = POS_W'(START_X);
    localparam logic [POS_W-1:0] START_YP = POS_W'(START_Y);
    localparam logic [POS_W-1:0] HI_LIM   = POS_W'(FIELD_MAX - GRID);
    localparam logic [POS_W-1:0] LO_LIM   = POS_W'(FIELD_MIN + GRID);
    localparam logic [POS_W-1:0] V_TICK_P = POS_W'(V_TICK);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

`ifdef SNAKE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam logic [1:0] DIR_R = 2'd0;
    localparam logic [1:0] DIR_D = 2'd1;
    localparam logic [1:0] DIR_L = 2'd2;
    localparam logic [1:0] DIR_U = 2'd3;

    state_t             state_q, state_nxt;
    logic [POS_W-1:0]   x_q, x_nxt;
    logic [POS_W-1:0]   y_q, y_nxt;
    logic [1:0]         dir_q, dir_nxt;
    logic               pend_valid_q, pend_valid_nxt;
    logic [1:0]         pend_dir_q, pend_dir_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic               step_d_q, step_d_nxt;
    logic               step_q;
    logic               ready_q, ready_nxt;
    logic               over_q, over_nxt;

    logic               tick_c;
    logic               xfer_c;
    logic               step_c;
    logic [1:0]         eff_dir_c;
    logic               hit_c;
    logic [POS_W-1:0]   x_mv_c, y_mv_c;

    // Frame tick: first pixel of the first blanking line
    assign tick_c = (i_vcnt == V_TICK_P) && (i_hcnt == '0);
    assign xfer_c = i_dir_valid && ready_q;

    // State register
    always_ff @(posedge i_clk_74M) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            x_q          <= START_XP;
            y_q          <= START_YP;
            dir_q        <= DIR_R;
            pend_valid_q <= 1'b0;
            pend_dir_q   <= DIR_R;
            cnt_q        <= '0;
            step_d_q     <= 1'b0;
            step_q       <= 1'b0;
            ready_q      <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            x_q          <= x_nxt;
            y_q          <= y_nxt;
            dir_q        <= dir_nxt;
            pend_valid_q <= pend_valid_nxt;
            pend_dir_q   <= pend_dir_nxt;
            cnt_q        <= cnt_nxt;
            step_d_q     <= step_d_nxt;
            step_q       <= step_d_q;
            ready_q      <= ready_nxt;
            over_q       <= over_nxt;
        end
    end

    // Next-state, step sequencing and movement
    always_comb begin
        state_nxt      = state_q;
        x_nxt          = x_q;
        y_nxt          = y_q;
        dir_nxt        = dir_q;
        pend_valid_nxt = pend_valid_q;
        pend_dir_nxt   = pend_dir_q;
        cnt_nxt        = cnt_q;
        step_d_nxt     = 1'b0;
        step_c         = 1'b0;
        hit_c          = 1'b0;
        x_mv_c         = x_q;
        y_mv_c         = y_q;

        // Pending entry applies unless it reverses the current heading
        eff_dir_c = dir_q;
        if (pend_valid_q && (pend_dir_q != (dir_q ^ 2'd2))) begin
            eff_dir_c = pend_dir_q;
        end

        // Bounds are checked before add/sub so the 12-bit math never wraps
        case (eff_dir_c)
            DIR_R: begin
                if (x_q > HI_LIM) begin hit_c = 1'b1; x_mv_c = FMIN_P; end
                else              x_mv_c = x_q + GRID_P;
            end
            DIR_L: begin
                if (x_q < LO_LIM) begin hit_c = 1'b1; x_mv_c = FMAX_P; end
                else              x_mv_c = x_q - GRID_P;
            end
            DIR_D: begin
                if (y_q > HI_LIM) begin hit_c = 1'b1; y_mv_c = FMIN_P; end
                else              y_mv_c = y_q + GRID_P;
            end
            DIR_U: begin
                if (y_q < LO_LIM) begin hit_c = 1'b1; y_mv_c = FMAX_P; end
                else              y_mv_c = y_q - GRID_P;
            end
            default: ;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                if (tick_c) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_nxt = '0;
                        step_c  = 1'b1;
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end
                if (step_c) begin
                    step_d_nxt = 1'b1;
                    dir_nxt    = eff_dir_c;
                    if (hit_c && !WRAP_EN) begin
                        state_nxt = ST_DEAD;
                    end else begin
                        x_nxt = x_mv_c;
                        y_nxt = y_mv_c;
                    end
                end
                // A command accepted on the step cycle waits for the next step
                pend_valid_nxt = (pend_valid_q && !step_c) || xfer_c;
                if (xfer_c) begin
                    pend_dir_nxt = i_dir;
                end
            end
            ST_DEAD: begin
                if (i_start) begin
                    state_nxt      = ST_RUN;
                    x_nxt          = START_XP;
                    y_nxt          = START_YP;
                    dir_nxt        = DIR_R;
                    pend_valid_nxt = 1'b0;
                    cnt_nxt        = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        ready_nxt = (state_nxt == ST_RUN) && !pend_valid_nxt;
        over_nxt  = (state_nxt == ST_DEAD) && !WRAP_EN;
    end

    assign o_dir_ready = ready_q;
    assign o_x_pos     = x_q;
    assign o_y_pos     = y_q;
    assign o_step      = step_q;
    assign o_state     = state_q;
    assign o_game_over = over_q;

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Directed bench for snake_head_ctrl: reset values, stepping cadence,
// direction handshake and reversal rejection, wall collision or wrap,
// and reset in the middle of a step interval.
module tb_snake_head_ctrl;

    logic        clk;
    logic        rst_n;
    logic [11:0] vcnt;
    logic [11:0] hcnt;
    logic        start;
    logic        dir_valid;
    logic [1:0]  dir;
    logic        dir_ready;
    logic [11:0] x_pos;
    logic [11:0] y_pos;
    logic        step;
    logic [1:0]  state;
    logic        game_over;

    int tests;
    int fails;

    snake_head_ctrl dut (
        .i_clk_74M   (clk),
        .i_rst_n     (rst_n),
        .i_vcnt      (vcnt),
        .i_hcnt      (hcnt),
        .i_start     (start),
        .i_dir_valid (dir_valid),
        .i_dir       (dir),
        .o_dir_ready (dir_ready),
        .o_x_pos     (x_pos),
        .o_y_pos     (y_pos),
        .o_step      (step),
        .o_state     (state),
        .o_game_over (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame tick; optionally offer a direction in the same cycle
    task automatic tick(input bit with_dir, input logic [1:0] d);
        @(negedge clk);
        vcnt = 12'd720;
        hcnt = 12'd0;
        if (with_dir) begin
            dir_valid = 1'b1;
            dir       = d;
        end
        @(negedge clk);
        vcnt = 12'd0;
        hcnt = 12'd1;
        if (with_dir) dir_valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 2'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic offer_dir(input logic [1:0] d);
        @(negedge clk);
        dir_valid = 1'b1;
        dir       = d;
        @(negedge clk);
        dir_valid = 1'b0;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        vcnt      = 12'd0;
        hcnt      = 12'd1;
        start     = 1'b0;
        dir_valid = 1'b0;
        dir       = 2'd0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_x", x_pos, 12'd320);
        chk("rst_y", y_pos, 12'd320);
        chk("rst_state", 12'(state), 12'd0);
        chk("rst_ready", 12'(dir_ready), 12'd0);
        chk("rst_step", 12'(step), 12'd0);
        chk("rst_over", 12'(game_over), 12'd0);
        rst_n = 1'b1;

        // Ticks in IDLE are ignored
        ticks(8);
        chk("idle_x", x_pos, 12'd320);
        chk("idle_state", 12'(state), 12'd0);

        // 1: start, eight ticks, default direction right
        pulse_start();
        chk("t1_state", 12'(state), 12'd1);
        chk("t1_ready", 12'(dir_ready), 12'd1);
        ticks(7);
        chk("t1_x_pre", x_pos, 12'd320);
        chk("t1_step_pre", 12'(step), 12'd0);
        tick(1'b0, 2'd0);
        chk("t1_x", x_pos, 12'd352);
        chk("t1_y", y_pos, 12'd320);
        chk("t1_step_lag", 12'(step), 12'd0);
        @(negedge clk);
        chk("t1_step_hi", 12'(step), 12'd1);
        @(negedge clk);
        chk("t1_step_lo", 12'(step), 12'd0);
        chk("t1_state_run", 12'(state), 12'd1);

        // 2: down accepted, up held off until the step, then up rejected as reversal
        dir_valid = 1'b1;
        dir       = 2'd1;
        @(negedge clk);
        dir = 2'd3;
        chk("t2_ready_full", 12'(dir_ready), 12'd0);
        ticks(7);
        chk("t2_ready_held", 12'(dir_ready), 12'd0);
        tick(1'b0, 2'd0);
        chk("t2_y", y_pos, 12'd352);
        chk("t2_x", x_pos, 12'd352);
        chk("t2_ready_free", 12'(dir_ready), 12'd1);
        @(negedge clk);
        chk("t2_ready_took", 12'(dir_ready), 12'd0);
        dir_valid = 1'b0;
        ticks(8);
        chk("t2_rev_y", y_pos, 12'd384);
        chk("t2_rev_x", x_pos, 12'd352);
        chk("t2_ready_end", 12'(dir_ready), 12'd1);

        // 4: command on the step cycle applies only to the following step
        ticks(7);
        tick(1'b1, 2'd0);
        chk("t4_y_old", y_pos, 12'd416);
        chk("t4_x_old", x_pos, 12'd352);
        chk("t4_ready", 12'(dir_ready), 12'd0);
        ticks(8);
        chk("t4_x_new", x_pos, 12'd384);
        chk("t4_y_new", y_pos, 12'd416);

        // Drive right up to the last legal column
        ticks(48);
        chk("edge_x", x_pos, 12'd576);
        chk("edge_state", 12'(state), 12'd1);

`ifndef SNAKE_WRAP_EN
        // 3: collision at the right wall, then restart
        ticks(8);
        chk("t3_state", 12'(state), 12'd2);
        chk("t3_over", 12'(game_over), 12'd1);
        chk("t3_x", x_pos, 12'd576);
        chk("t3_y", y_pos, 12'd416);
        chk("t3_ready", 12'(dir_ready), 12'd0);
        @(negedge clk);
        chk("t3_step", 12'(step), 12'd1);
        ticks(8);
        chk("t3_dead_x", x_pos, 12'd576);
        chk("t3_dead_state", 12'(state), 12'd2);
        pulse_start();
        chk("t3_rs_state", 12'(state), 12'd1);
        chk("t3_rs_x", x_pos, 12'd320);
        chk("t3_rs_y", y_pos, 12'd320);
        chk("t3_rs_over", 12'(game_over), 12'd0);
        chk("t3_rs_ready", 12'(dir_ready), 12'd1);
        ticks(8);
        chk("t3_rs_step_x", x_pos, 12'd352);
        chk("t3_rs_step_y", y_pos, 12'd320);
`else
        // 6: wrap at every wall, no game over
        ticks(8);
        chk("t6_wrap_r", x_pos, 12'd32);
        chk("t6_state", 12'(state), 12'd1);
        chk("t6_over", 12'(game_over), 12'd0);
        offer_dir(2'd1);
        ticks(40);
        chk("t6_y_edge", y_pos, 12'd576);
        ticks(8);
        chk("t6_wrap_d", y_pos, 12'd32);
        chk("t6_x_keep", x_pos, 12'd32);
        offer_dir(2'd2);
        ticks(8);
        chk("t6_wrap_l", x_pos, 12'd576);
        chk("t6_over_end", 12'(game_over), 12'd0);
        chk("t6_state_end", 12'(state), 12'd1);
`endif

        // 5: reset at cnt=5 with a pending command
        ticks(5);
        offer_dir(2'd1);
        chk("t5_pend", 12'(dir_ready), 12'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_x", x_pos, 12'd320);
        chk("t5_y", y_pos, 12'd320);
        chk("t5_state", 12'(state), 12'd0);
        chk("t5_ready", 12'(dir_ready), 12'd0);
        chk("t5_step", 12'(step), 12'd0);
        chk("t5_over", 12'(game_over), 12'd0);
        rst_n = 1'b1;
        pulse_start();
        chk("t5_run", 12'(state), 12'd1);
        chk("t5_ready_run", 12'(dir_ready), 12'd1);
        ticks(7);
        chk("t5_cnt_clr", x_pos, 12'd320);
        tick(1'b0, 2'd0);
        chk("t5_after_x", x_pos, 12'd352);
        chk("t5_after_y", y_pos, 12'd320);

        // start is ignored while running
        pulse_start();
        chk("run_start_x", x_pos, 12'd352);
        chk("run_start_state", 12'(state), 12'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
